// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// Op and state encodings plus a two's-complement magnitude helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } md_state_e;

  localparam int MD_MAXW = 64;

  // Low w bits of the result hold |v| when v is read as a w-bit signed value.
  function automatic logic [MD_MAXW-1:0] md_abs(
    input logic [MD_MAXW-1:0] v,
    input int unsigned        w
  );
    return v[w-1] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage <-> mul/div sequencer bundle.
// master drives issue/move requests, slave returns HI/LO and stall.
interface muldiv_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_req;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, a, b,
    output rd_req, wr_hi, wr_lo, wr_data,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, a, b,
    input  rd_req, wr_hi, wr_lo, wr_data,
    output hi, lo, busy, done, stall
  );

endinterface

// File: rtl/muldiv_iter.sv
// One iteration of the mul/div loop: shift-add multiply
// or restoring-divide step on the 2*WIDTH accumulator.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0])
      sum = sum + {1'b0, opnd};
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    ge     = rem_sh >= {1'b0, opnd};
    diff   = rem_sh[WIDTH-1:0] - opnd;
    if (!div)
      acc_next = {sum, acc[WIDTH-1:1]};
    else if (ge)
      acc_next = {diff, acc[WIDTH-2:0], 1'b1};
    else
      acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative mult/multu/div/divu sequencer owning HI/LO.
// Signed ops run on magnitudes; signs are restored in FIX.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state, state_next;
  md_op_e             op_in;
  logic [CW-1:0]      count;
  logic               div_q, neg_res, neg_rem, dz;
  logic [2*WIDTH-1:0] acc, acc_next, prod;
  logic [WIDTH-1:0]   opnd, a_mag, b_mag, load_lo;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   hi, lo;
  logic               done, busy, stall;
  logic               sgn, is_div, dz_in, accept;

  assign busy   = state != MD_IDLE;
  assign stall  = busy & (bus.start | bus.rd_req |
                          bus.wr_hi | bus.wr_lo);
  assign accept = bus.start & ~busy;

  assign bus.hi    = hi;
  assign bus.lo    = lo;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.stall = stall;

  always_comb begin
    op_in  = md_op_e'(bus.op);
    sgn    = (op_in == MD_MULT) || (op_in == MD_DIV);
    is_div = (op_in == MD_DIV) || (op_in == MD_DIVU);
    dz_in  = is_div && (bus.b == '0);
    a_mag  = sgn ? WIDTH'(md_abs(MD_MAXW'(bus.a), WIDTH)) : bus.a;
    b_mag  = sgn ? WIDTH'(md_abs(MD_MAXW'(bus.b), WIDTH)) : bus.b;
    // Divide-by-zero keeps the raw dividend so FIX can return it in HI.
    load_lo = dz_in ? bus.a : (is_div ? a_mag : b_mag);
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .div      (div_q),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  always_comb begin
    prod     = neg_res ? -acc : acc;
    quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH]
                       : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= MD_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      MD_IDLE:
        if (accept)
          state_next = dz_in ? MD_FIX : MD_RUN;
      MD_RUN:
        if (count == '0)
          state_next = MD_FIX;
      MD_FIX:
        state_next = MD_IDLE;
      default:
        state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      div_q   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      acc     <= '0;
      opnd    <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.wr_hi && !stall)
        hi <= bus.wr_data;
      if (bus.wr_lo && !stall)
        lo <= bus.wr_data;
      unique case (state)
        MD_IDLE:
          if (accept) begin
            div_q   <= is_div;
            neg_res <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem <= sgn & bus.a[WIDTH-1];
            dz      <= dz_in;
            count   <= CW'(WIDTH - 1);
            acc     <= {{WIDTH{1'b0}}, load_lo};
            opnd    <= is_div ? b_mag : a_mag;
          end
        MD_RUN: begin
          acc   <= acc_next;
          count <= count - CW'(1);
        end
        MD_FIX: begin
          done <= 1'b1;
          if (dz) begin
            hi <= acc[WIDTH-1:0];
            lo <= '1;
          end else if (div_q) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic, latency, stall,
// mthi/mtlo and reset abort, against hand-computed values.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.a       = '0;
    bus.b       = '0;
    bus.rd_req  = 1'b0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.wr_data = '0;
  endtask

  // Leaves the caller at the falling edge after the accept edge.
  task automatic issue(input logic [1:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // k = rising edges after the accept edge until done is seen.
  task automatic wait_done(output int k);
    k = 0;
    while (bus.done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.hi !== 32'h0) begin
      n_err++; $display("FAIL rst_hi got %h want 0", bus.hi);
    end
    n_vec++;
    if (bus.lo !== 32'h0) begin
      n_err++; $display("FAIL rst_lo got %h want 0", bus.lo);
    end
    n_vec++;
    if ({bus.busy, bus.done, bus.stall} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_flags got %b want 000",
               {bus.busy, bus.done, bus.stall});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_multu_max();
    int k;
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(k);
    n_vec++;
    if (k !== 33) begin
      n_err++; $display("FAIL multu_lat got %0d want 33", k);
    end
    n_vec++;
    if (bus.hi !== 32'hFFFF_FFFE) begin
      n_err++; $display("FAIL multu_hi got %h want fffffffe", bus.hi);
    end
    n_vec++;
    if (bus.lo !== 32'h0000_0001) begin
      n_err++; $display("FAIL multu_lo got %h want 00000001", bus.lo);
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL multu_busy got %b want 0", bus.busy);
    end
    @(negedge clk);
    n_vec++;
    if (bus.done !== 1'b0) begin
      n_err++; $display("FAIL multu_pulse got %b want 0", bus.done);
    end
  endtask

  task automatic test_signed();
    int k;
    issue(MD_MULT, 32'hFFFF_FFF9, 32'd3);
    wait_done(k);
    n_vec++;
    if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFEB || k !== 33) begin
      n_err++;
      $display("FAIL mult_neg got %h/%h k=%0d want ffffffff/ffffffeb k=33",
               bus.hi, bus.lo, k);
    end
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(k);
    n_vec++;
    if (bus.lo !== 32'hFFFF_FFFD || k !== 33) begin
      n_err++;
      $display("FAIL div_neg_q got %h k=%0d want fffffffd k=33",
               bus.lo, k);
    end
    n_vec++;
    if (bus.hi !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL div_neg_r got %h want ffffffff", bus.hi);
    end
  endtask

  task automatic test_divu();
    int k;
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done(k);
    n_vec++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || k !== 33) begin
      n_err++;
      $display("FAIL divu got q=%0d r=%0d k=%0d want q=14 r=2 k=33",
               bus.lo, bus.hi, k);
    end
  endtask

  task automatic test_overflow();
    int k;
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(k);
    n_vec++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
      n_err++;
      $display("FAIL div_ovf got %h/%h want lo=80000000 hi=0",
               bus.lo, bus.hi);
    end
  endtask

  task automatic test_div_zero();
    int k;
    issue(MD_DIVU, 32'd5, 32'd0);
    wait_done(k);
    // FIX is entered straight from the accept edge.
    n_vec++;
    if (k !== 1) begin
      n_err++; $display("FAIL divz_lat got %0d want 1", k);
    end
    n_vec++;
    if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd5) begin
      n_err++;
      $display("FAIL divuz got %h/%h want lo=ffffffff hi=5",
               bus.lo, bus.hi);
    end
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done(k);
    n_vec++;
    if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'hFFFF_FFF9 || k !== 1) begin
      n_err++;
      $display("FAIL divz_sgn got %h/%h k=%0d want ffffffff/fffffff9 k=1",
               bus.lo, bus.hi, k);
    end
  endtask

  task automatic test_stall_read();
    int n;
    int bad;
    issue(MD_MULTU, 32'd6, 32'd7);
    repeat (2) @(negedge clk);
    bus.rd_req = 1'b1;
    n   = 0;
    bad = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      #1;
      if (bus.stall !== 1'b1) bad++;
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (bad !== 0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rd_stall got bad=%0d busy=%b want 0/0",
               bad, bus.busy);
    end
    n_vec++;
    if (bus.stall !== 1'b0 || bus.lo !== 32'd42 || bus.hi !== 32'd0) begin
      n_err++;
      $display("FAIL rd_value got st=%b %h/%h want 0 0/2a",
               bus.stall, bus.hi, bus.lo);
    end
    bus.rd_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    int bad;
    int k;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MD_MULTU;
    bus.a     = 32'd5;
    bus.b     = 32'd5;
    @(negedge clk);
    bus.op = MD_DIVU;
    bus.a  = 32'd100;
    bus.b  = 32'd7;
    n   = 0;
    bad = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      #1;
      if (bus.stall !== 1'b1) bad++;
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (bad !== 0 || n !== 33) begin
      n_err++;
      $display("FAIL b2b_hold got bad=%0d n=%0d want 0/33", bad, n);
    end
    n_vec++;
    if (bus.lo !== 32'd25 || bus.hi !== 32'd0 || bus.stall !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first got %h/%h st=%b want 0/19 st=0",
               bus.hi, bus.lo, bus.stall);
    end
    @(negedge clk);
    bus.start = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_accept got %b want 1", bus.busy);
    end
    wait_done(k);
    n_vec++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || k !== 33) begin
      n_err++;
      $display("FAIL b2b_second got q=%0d r=%0d k=%0d want 14/2/33",
               bus.lo, bus.hi, k);
    end
  endtask

  task automatic test_mt_writes();
    int k;
    @(negedge clk);
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'h1234;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    n_vec++;
    if (bus.hi !== 32'h1234) begin
      n_err++; $display("FAIL mthi got %h want 1234", bus.hi);
    end
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'h5678;
    @(negedge clk);
    bus.wr_lo = 1'b0;
    n_vec++;
    if (bus.lo !== 32'h5678 || bus.hi !== 32'h1234) begin
      n_err++;
      $display("FAIL mtlo got %h/%h want 1234/5678", bus.hi, bus.lo);
    end
    bus.wr_hi   = 1'b1;
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'hABCD;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    n_vec++;
    if (bus.hi !== 32'hABCD || bus.lo !== 32'hABCD) begin
      n_err++;
      $display("FAIL mt_both got %h/%h want abcd/abcd", bus.hi, bus.lo);
    end
    bus.start   = 1'b1;
    bus.op      = MD_MULTU;
    bus.a       = 32'd3;
    bus.b       = 32'd4;
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'h99;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    n_vec++;
    if (bus.hi !== 32'h99 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL mt_start got hi=%h busy=%b want 99/1",
               bus.hi, bus.busy);
    end
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'h77;
    #1;
    n_vec++;
    if (bus.stall !== 1'b1) begin
      n_err++; $display("FAIL mt_busy_stall got %b want 1", bus.stall);
    end
    @(negedge clk);
    bus.wr_lo = 1'b0;
    n_vec++;
    if (bus.lo !== 32'hABCD) begin
      n_err++; $display("FAIL mt_busy_drop got %h want abcd", bus.lo);
    end
    wait_done(k);
    n_vec++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
      n_err++;
      $display("FAIL mt_overwrite got %h/%h want 0/c", bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_abort();
    int k;
    int pulses;
    @(negedge clk);
    bus.wr_hi   = 1'b1;
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'h55;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    issue(MD_DIVU, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_rst got %h/%h busy=%b want 0/0/0",
               bus.hi, bus.lo, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses !== 0 || bus.lo !== 32'd0) begin
      n_err++;
      $display("FAIL abort_done got pulses=%0d lo=%h want 0/0",
               pulses, bus.lo);
    end
    issue(MD_MULTU, 32'd3, 32'd4);
    wait_done(k);
    n_vec++;
    if (bus.lo !== 32'd12 || bus.hi !== 32'd0 || k !== 33) begin
      n_err++;
      $display("FAIL abort_after got %h/%h k=%0d want 0/c k=33",
               bus.hi, bus.lo, k);
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_divu();
    test_overflow();
    test_div_zero();
    test_stall_read();
    test_back_to_back();
    test_mt_writes();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
